// File: rtl/cpu_pkg.sv
// Shared constants and packet type for the fetch stage.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Control, instruction-memory and decode-side signals of the fetch stage.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic                fetch_en;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_pc;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_instr;
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_instr;
    logic [ADDR_W-1:0]   out_pc;

    // Fetch stage side.
    modport master (
        input  fetch_en, redirect_valid, redirect_pc, imem_instr, out_ready,
        output imem_addr, out_valid, out_instr, out_pc
    );

    // Environment side: control, memory and decode.
    modport slave (
        output fetch_en, redirect_valid, redirect_pc, imem_instr, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched packets; head is always presented, flush empties it.
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  fetch_pkt_t push_data,
    input  logic       pop,
    output fetch_pkt_t head,
    output logic [1:0] count
);

    fetch_pkt_t mem_q [2];
    fetch_pkt_t mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    // Next-state: flush wins, otherwise simultaneous push and pop both apply.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage and pointer registers; reset clears storage so the head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            assert (!(push && !pop && !flush && count_q == 2'd2));
        end
    end

    // Head entry drives the consumer directly.
    always_comb begin
        head  = mem_q[rd_ptr_q];
        count = count_q;
    end

endmodule

// File: rtl/fetch_unit.sv
// PC generation, in-flight tracking for the registered instruction memory,
// redirect/squash handling and the output queue feeding decode.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic       out_valid;
    logic       pop;
    logic       issue;
    logic       fifo_push;
    logic       fifo_pop;
    logic [1:0] fifo_count;
    logic [2:0] occ_after_pop;
    fetch_pkt_t push_pkt;
    fetch_pkt_t head_pkt;
    logic       unused_redirect_lsb;

    assign unused_redirect_lsb = bus.redirect_pc[0];

    // Issue decision: only fetch when the word is guaranteed a queue slot.
    always_comb begin
        out_valid     = (fifo_count != 2'd0);
        pop           = out_valid & bus.out_ready;
        occ_after_pop = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
        issue         = bus.fetch_en & ~bus.redirect_valid & ~rst & (occ_after_pop < 3'd2);
    end

    // Next PC / in-flight state; redirect overrides everything else.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[ADDR_W-1:1], 1'b0};
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + PC_STEP;
        end
    end

    // PC and in-flight registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Returning word is squashed on redirect; a pop during redirect is void.
    always_comb begin
        fifo_push      = inflight_q & ~bus.redirect_valid;
        fifo_pop       = pop & ~bus.redirect_valid;
        push_pkt.instr = bus.imem_instr;
        push_pkt.pc    = inflight_pc_q;
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (fifo_push),
        .push_data (push_pkt),
        .pop       (fifo_pop),
        .head      (head_pkt),
        .count     (fifo_count)
    );

    // Output drive: memory address is the PC register, decode sees the queue head.
    always_comb begin
        bus.imem_addr = fetch_pc_q;
        bus.out_valid = out_valid;
        bus.out_instr = head_pkt.instr;
        bus.out_pc    = head_pkt.pc;
    end

endmodule
